// File: rtl/qsys_pio_pkg.sv
// Shared constants for the Qsys PIO blocks: register word addresses and edge-type encodings.
package qsys_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/qsys_input_pio_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// No waitrequest: a strobe qualified by chipselect completes on the clk edge that samples it;
// readdata is registered (latency 1) and holds until the next read. read_n and write_n are exclusive.
interface qsys_input_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, read_n, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_debounce.sv
// Single-bit 2-flop synchroniser followed by a stable-count debouncer.
module pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_pin,
    input  logic i_armed,
    output logic o_level
);
    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
        end
    end

    // Before arming the level follows sync directly so pins held through reset are absorbed silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (!i_armed || DEBOUNCE_CYCLES == 0) begin
            r_level <= r_sync;
            r_cnt   <= '0;
        end else if (r_sync == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_level <= r_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_level = r_level;
endmodule

// File: rtl/qsys_input_pio.sv
// Avalon-MM input PIO: debounced pins, per-bit edge capture with W1C, interrupt mask and level IRQ.
module qsys_input_pio
    import qsys_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = EDGE_FALL,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    qsys_input_pio_if.slave      avs,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
    localparam int ARM_STAGES = 4;

    logic [ARM_STAGES-1:0] r_arm;
    logic                  w_load_done;
    logic                  w_edge_en;
    logic [WIDTH-1:0]      w_filtered;
    logic [WIDTH-1:0]      r_filtered_d;
    logic [WIDTH-1:0]      r_edge_cap;
    logic [WIDTH-1:0]      r_irq_mask;
    logic [WIDTH-1:0]      w_event;
    logic [WIDTH-1:0]      w_wdata;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_unused_wdata;

    // Filtered tracks sync until the synchroniser has flushed; edges wait one more cycle for filtered_d.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_arm <= '0;
        else          r_arm <= {r_arm[ARM_STAGES-2:0], 1'b1};
    end
    assign w_load_done = r_arm[ARM_STAGES-2];
    assign w_edge_en   = r_arm[ARM_STAGES-1];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .i_pin   (in_port[gi]),
            .i_armed (w_load_done),
            .o_level (w_filtered[gi])
        );
    end

    always_comb begin
        w_event = '0;
        if (w_edge_en) begin
            case (EDGE_TYPE)
                EDGE_RISE: w_event = w_filtered & ~r_filtered_d;
                EDGE_FALL: w_event = ~w_filtered & r_filtered_d;
                default:   w_event = w_filtered ^ r_filtered_d;
            endcase
        end
    end

    assign w_wr           = avs.chipselect & ~avs.write_n;
    assign w_rd           = avs.chipselect & ~avs.read_n;
    assign w_wdata        = avs.writedata[WIDTH-1:0];
    assign w_unused_wdata = &{1'b0, avs.writedata};

    // A new event on a bit wins over a W1C clear of that bit in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filtered_d <= '0;
            r_edge_cap   <= '0;
            r_irq_mask   <= '0;
        end else begin
            r_filtered_d <= w_filtered;
            if (w_wr && avs.address == PIO_ADDR_EDGECAP)
                r_edge_cap <= (r_edge_cap & ~w_wdata) | w_event;
            else
                r_edge_cap <= r_edge_cap | w_event;
            if (w_wr && avs.address == PIO_ADDR_IRQMASK)
                r_irq_mask <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs.readdata <= '0;
        end else if (w_rd) begin
            case (avs.address)
                PIO_ADDR_DATA:    avs.readdata <= 32'(w_filtered);
                PIO_ADDR_IRQMASK: avs.readdata <= 32'(r_irq_mask);
                PIO_ADDR_EDGECAP: avs.readdata <= 32'(r_edge_cap);
                default:          avs.readdata <= '0;
            endcase
        end
    end

    assign irq = |(r_edge_cap & r_irq_mask);
endmodule

// File: tb/tb_qsys_input_pio.sv
// Directed plus randomized bench for qsys_input_pio (WIDTH=4, falling edge, 4-cycle debounce).
module tb_qsys_input_pio;
    import qsys_pio_pkg::*;

    localparam int W   = 4;
    localparam int DEB = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic         irq;

    qsys_input_pio_if pio_if ();

    qsys_input_pio #(
        .WIDTH           (W),
        .EDGE_TYPE       (EDGE_FALL),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (pio_if),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: filtered level is the last pin value held long enough; falling bits accumulate.
    logic [W-1:0] m_filt;
    logic [W-1:0] m_cap;
    logic [W-1:0] m_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        pio_if.address    = addr;
        pio_if.writedata  = data;
        pio_if.chipselect = 1'b1;
        pio_if.write_n    = 1'b0;
        @(negedge clk);
        pio_if.chipselect = 1'b0;
        pio_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        pio_if.address    = addr;
        pio_if.chipselect = 1'b1;
        pio_if.read_n     = 1'b0;
        @(negedge clk);
        pio_if.chipselect = 1'b0;
        pio_if.read_n     = 1'b1;
        data = pio_if.readdata;
    endtask

    task automatic hold_pins(input logic [W-1:0] val, input int cycles);
        in_port = val;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic apply_level(input logic [W-1:0] val);
        hold_pins(val, DEB + 6);
        m_cap  = m_cap | (m_filt & ~val);
        m_filt = val;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] rd;
        bus_read(PIO_ADDR_DATA, rd);
        chk({tag, "_data"}, rd, 32'(m_filt));
        bus_read(PIO_ADDR_EDGECAP, rd);
        chk({tag, "_edgecap"}, rd, 32'(m_cap));
        chk({tag, "_irq"}, 32'(irq), 32'(|(m_cap & m_mask)));
    endtask

    initial begin
        logic [31:0] rd;
        logic [W-1:0] g;
        logic [W-1:0] nv;
        int k;

        reset_n           = 1'b0;
        in_port           = 4'hF;
        pio_if.address    = 2'd0;
        pio_if.chipselect = 1'b0;
        pio_if.read_n     = 1'b1;
        pio_if.write_n    = 1'b1;
        pio_if.writedata  = 32'h0;
        m_filt = 4'hF;
        m_cap  = '0;
        m_mask = '0;

        repeat (3) @(negedge clk);
        chk("reset_readdata", pio_if.readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check_model("post_reset");

        // Falling edge on bit 0: filtered changes on the 6th edge, so a read on edge 7 sees it.
        in_port           = 4'hE;
        pio_if.address    = PIO_ADDR_DATA;
        pio_if.chipselect = 1'b1;
        pio_if.read_n     = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 6) chk("data0_edge6_old", 32'(pio_if.readdata[0]), 32'h1);
            if (i == 7) chk("data0_edge7_new", 32'(pio_if.readdata[0]), 32'h0);
        end
        pio_if.chipselect = 1'b0;
        pio_if.read_n     = 1'b1;
        m_filt = 4'hE;
        m_cap  = 4'h1;
        check_model("fall_bit0");

        hold_pins(4'hC, 3);
        hold_pins(4'hE, DEB + 6);
        check_model("glitch_bit1");

        bus_write(PIO_ADDR_IRQMASK, 32'h1);
        m_mask = 4'h1;
        chk("irq_after_unmask", 32'(irq), 32'h1);
        bus_write(PIO_ADDR_EDGECAP, 32'h2);
        chk("irq_after_w1c_other", 32'(irq), 32'h1);
        bus_read(PIO_ADDR_EDGECAP, rd);
        chk("edgecap_after_w1c_other", rd, 32'h1);
        bus_write(PIO_ADDR_EDGECAP, 32'h1);
        chk("irq_after_w1c", 32'(irq), 32'h0);
        m_cap = '0;
        bus_read(PIO_ADDR_EDGECAP, rd);
        chk("edgecap_after_w1c", rd, 32'h0);

        // Bit 2 falls; its capture edge is the 7th after the pin change, collide a W1C with it.
        in_port = 4'hA;
        repeat (6) @(negedge clk);
        bus_write(PIO_ADDR_EDGECAP, 32'h4);
        m_filt = 4'hA;
        m_cap  = 4'h4;
        repeat (3) @(negedge clk);
        check_model("set_wins");
        bus_write(PIO_ADDR_EDGECAP, 32'h4);
        m_cap = '0;

        bus_read(PIO_ADDR_RSVD, rd);
        chk("reserved_read", rd, 32'h0);
        bus_write(PIO_ADDR_DATA, 32'hFFFF_FFFF);
        bus_read(PIO_ADDR_DATA, rd);
        chk("data_write_ignored", rd, 32'(m_filt));
        bus_write(PIO_ADDR_IRQMASK, 32'hFFFF_FFFF);
        m_mask = 4'hF;
        bus_read(PIO_ADDR_IRQMASK, rd);
        chk("irqmask_readback", rd, 32'h0000_000F);

        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                g = W'($urandom_range(1, 15));
                k = $urandom_range(1, DEB - 1);
                hold_pins(m_filt ^ g, k);
                hold_pins(m_filt, 2);
            end
            nv = W'($urandom_range(0, 15));
            apply_level(nv);
            check_model("rand_step");
            g = W'($urandom_range(0, 15));
            bus_write(PIO_ADDR_EDGECAP, 32'(g));
            m_cap = m_cap & ~g;
            g = W'($urandom_range(0, 15));
            bus_write(PIO_ADDR_IRQMASK, {$urandom_range(0, 65535), 12'h0, g});
            m_mask = g;
            chk("rand_irq", 32'(irq), 32'(|(m_cap & m_mask)));
        end

        // Asynchronous reset mid-operation with irq high and a nonzero readdata.
        apply_level(4'hF);
        apply_level(4'h0);
        bus_write(PIO_ADDR_IRQMASK, 32'hF);
        m_mask = 4'hF;
        bus_read(PIO_ADDR_EDGECAP, rd);
        chk("pre_reset_edgecap", rd, 32'(m_cap));
        chk("pre_reset_irq", 32'(irq), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_irq", 32'(irq), 32'h0);
        chk("async_reset_readdata", pio_if.readdata, 32'h0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_cap  = '0;
        m_mask = '0;
        repeat (8) @(negedge clk);
        check_model("after_mid_reset");
        bus_read(PIO_ADDR_IRQMASK, rd);
        chk("after_mid_reset_mask", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
